// File: rtl/seg7_scan_driver_if.sv
// Load-side bus of the seven-segment scan driver: the value and decimal-point word
// offered by the producer, plus the driver's ready flag.
//
// Handshake: a word transfers on a posedge where load && ready are both 1. The producer
// keeps value_in/dp_in valid while load is high. ready is low while a word waits for the
// next frame boundary. A load presented while ready is low is dropped, not queued.
interface seg7_scan_driver_if #(
    parameter int DIGITS = 4
) ();
    logic [4*DIGITS-1:0] value_in;
    logic [DIGITS-1:0]   dp_in;
    logic                load;
    logic                ready;

    modport master (output value_in, output dp_in, output load, input ready);
    modport slave  (input value_in, input dp_in, input load, output ready);
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver. It double-buffers the display word and commits
// it only at a frame boundary. Each digit slot starts with a dead-time gap.
module seg7_scan_driver #(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int BLANK_CYC  = 8,
    parameter int HEX_MODE   = 0,
    parameter int BLANK_LZ   = 1,
    parameter int DIG_ACT_LO = 1
) (
    input  logic              clk,
    input  logic              rst,
    seg7_scan_driver_if.slave bus,
    output logic [7:0]        seg,
    output logic [DIGITS-1:0] digit_en
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIGITS-1:0] DIG_OFF = (DIG_ACT_LO != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [DW-1:0]       div;
    logic [IW-1:0]       idx;
    logic                pending_valid;
    logic [4*DIGITS-1:0] pend_val;
    logic [DIGITS-1:0]   pend_dp;
    logic [4*DIGITS-1:0] com_val;
    logic [DIGITS-1:0]   com_dp;

    logic                slot_end;
    logic                frame_end;
    logic                accept;
    logic                in_blank;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blank;
    logic [DIGITS-1:0]   onehot;
    logic [DIGITS-1:0]   lz_vec;
    logic                zero_above;

    assign bus.ready = ~pending_valid;
    assign slot_end  = (div == DW'(SCAN_DIV - 1));
    assign frame_end = slot_end && (idx == IW'(DIGITS - 1));
    assign accept    = bus.load && !pending_valid;
    assign in_blank  = (32'(div) < BLANK_CYC);

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        if (HEX_MODE == 0 && n > 4'd9) g = 7'h00;
        return g;
    endfunction

    // A digit is a leading zero when it and every digit above it show 0 with no dp lit.
    always_comb begin
        zero_above = 1'b1;
        lz_vec     = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above && (com_val[4*k +: 4] == 4'h0) && !com_dp[k];
            if (k > 0) lz_vec[k] = zero_above;
        end
    end

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        onehot    = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_nib   = com_val[4*k +: 4];
                cur_dp    = com_dp[k];
                cur_blank = lz_vec[k] && (BLANK_LZ != 0);
                onehot[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div           <= '0;
            idx           <= '0;
            pending_valid <= 1'b0;
            pend_val      <= '0;
            pend_dp       <= '0;
            com_val       <= '0;
            com_dp        <= '0;
            seg           <= 8'h00;
            digit_en      <= DIG_OFF;
        end else begin
            div <= slot_end ? '0 : div + DW'(1);
            if (slot_end) idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);

            // Commit and accept never coincide: one needs the flag set, the other clear.
            if (frame_end && pending_valid) begin
                com_val       <= pend_val;
                com_dp        <= pend_dp;
                pending_valid <= 1'b0;
            end else if (accept) begin
                pend_val      <= bus.value_in;
                pend_dp       <= bus.dp_in;
                pending_valid <= 1'b1;
            end

            if (in_blank) begin
                seg      <= 8'h00;
                digit_en <= DIG_OFF;
            end else begin
                seg      <= {cur_dp, cur_blank ? 7'h00 : glyph(cur_nib)};
                digit_en <= (DIG_ACT_LO != 0) ? ~onehot : onehot;
            end
        end
    end
endmodule
